// File: rtl/smu_dribbler_if.sv
// ---------------------------------------------------------------------------
// smu_dribbler_if
// Request/return bus between the stack-management dribbler and the DCU.
//   smu_req      : request valid, held until dcu_smu_ack
//   smu_st       : 1 = spill store, 0 = fill load
//   smu_addr     : word address of the request
//   smu_data     : store data for a spill
//   dcu_smu_ack  : DCU accepts the pending request
//   dcu_data_vld : fill return data valid
//   dcu_data     : fill return data
// master = dribbler side, slave = DCU side.
// ---------------------------------------------------------------------------
interface smu_dribbler_if;
    logic        smu_req;
    logic        smu_st;
    logic [31:0] smu_addr;
    logic [31:0] smu_data;
    logic        dcu_smu_ack;
    logic        dcu_data_vld;
    logic [31:0] dcu_data;

    modport master (
        output smu_req, smu_st, smu_addr, smu_data,
        input  dcu_smu_ack, dcu_data_vld, dcu_data
    );

    modport slave (
        input  smu_req, smu_st, smu_addr, smu_data,
        output dcu_smu_ack, dcu_data_vld, dcu_data
    );
endinterface

// File: rtl/smu_dribbler.sv
// ---------------------------------------------------------------------------
// smu_dribbler
// Background spill/fill engine for the stack cache (S$). When dribbling is
// enabled it spills the bottom S$ entry to memory if the cache is too full,
// or fills one word back from memory if it is too empty, tracking the memory
// address of the cache bottom in SC_BOTTOM (smu_sbase).
//
// Ports
//   pj_clk, pj_reset_l          : clock, asynchronous active-low reset
//   dribble_en                  : dribbling enable (PSR.DRE)
//   num_entries/low_mark/high_mark : S$ occupancy and fill/spill thresholds
//   und_flw_bit                 : 1 = nothing left in memory to fill
//   sbase_ld, sbase_in          : software write of SC_BOTTOM
//   sc_rd_data                  : bottom S$ entry (spill data source)
//   squash_fill                 : abort an outstanding fill
//   smu_sbase                   : current SC_BOTTOM
//   smu_we, smu_wdata           : S$ fill write
//   smu_sbase_we                : SC_BOTTOM update strobe (spill/fill done)
//   spill, fill                 : one-cycle completion pulses
//   less_than_6, dribble_stall  : occupancy status (combinational)
//   dcu                         : DCU request/return bus (master side)
// ---------------------------------------------------------------------------
module smu_dribbler (
    input  logic                 pj_clk,
    input  logic                 pj_reset_l,
    input  logic                 dribble_en,
    input  logic [5:0]           num_entries,
    input  logic [5:0]           low_mark,
    input  logic [5:0]           high_mark,
    input  logic                 und_flw_bit,
    input  logic                 sbase_ld,
    input  logic [31:0]          sbase_in,
    input  logic [31:0]          sc_rd_data,
    input  logic                 squash_fill,
    output logic [31:0]          smu_sbase,
    output logic                 smu_we,
    output logic [31:0]          smu_wdata,
    output logic                 smu_sbase_we,
    output logic                 spill,
    output logic                 fill,
    output logic                 less_than_6,
    output logic                 dribble_stall,
    smu_dribbler_if.master       dcu
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SPILL_REQ = 2'd1,
        FILL_REQ  = 2'd2,
        FILL_WAIT = 2'd3
    } state_t;

    state_t      state_q;
    logic        squashed_q;
    logic [31:0] sbase_q;
    logic [31:0] sbase_d;
    logic        req_q;
    logic        st_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        sbase_we_q;
    logic        spill_q;
    logic        fill_q;

    logic spill_cond;
    logic fill_cond;
    logic spill_ack;
    logic squash_now;
    logic fill_done;

    // Spill is tested first so it wins when misconfigured marks overlap.
    assign spill_cond = (num_entries > high_mark);
    assign fill_cond  = (num_entries < low_mark) && !und_flw_bit;

    assign spill_ack  = (state_q == SPILL_REQ) && dcu.dcu_smu_ack;
    // Returning data is dropped if the fill was squashed earlier, or if a
    // squash or SC_BOTTOM reload lands in the very cycle the data returns.
    assign squash_now = squashed_q || squash_fill || sbase_ld;
    assign fill_done  = (state_q == FILL_WAIT) && dcu.dcu_data_vld && !squash_now;

    // Software load overrides any hardware step; arithmetic wraps mod 2^32.
    always_comb begin
        sbase_d = sbase_q;
        if (spill_ack) begin
            sbase_d = sbase_q - 32'd4;
        end else if (fill_done) begin
            sbase_d = sbase_q + 32'd4;
        end
        if (sbase_ld) begin
            sbase_d = sbase_in;
        end
    end

    always_ff @(posedge pj_clk or negedge pj_reset_l) begin
        if (!pj_reset_l) begin
            state_q    <= IDLE;
            squashed_q <= 1'b0;
            sbase_q    <= 32'd0;
            req_q      <= 1'b0;
            st_q       <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            sbase_we_q <= 1'b0;
            spill_q    <= 1'b0;
            fill_q     <= 1'b0;
        end else begin
            // Completion strobes are single-cycle pulses.
            we_q       <= 1'b0;
            sbase_we_q <= 1'b0;
            spill_q    <= 1'b0;
            fill_q     <= 1'b0;
            sbase_q    <= sbase_d;

            unique case (state_q)
                IDLE: begin
                    // Address is taken from sbase_d so a same-cycle software
                    // load is honoured by the request it launches.
                    if (dribble_en && spill_cond) begin
                        state_q <= SPILL_REQ;
                        req_q   <= 1'b1;
                        st_q    <= 1'b1;
                        addr_q  <= sbase_d;
                        data_q  <= sc_rd_data;
                    end else if (dribble_en && fill_cond) begin
                        state_q <= FILL_REQ;
                        req_q   <= 1'b1;
                        st_q    <= 1'b0;
                        addr_q  <= sbase_d + 32'd4;
                    end
                end

                SPILL_REQ: begin
                    if (dcu.dcu_smu_ack) begin
                        state_q    <= IDLE;
                        req_q      <= 1'b0;
                        st_q       <= 1'b0;
                        spill_q    <= 1'b1;
                        sbase_we_q <= 1'b1;
                    end
                end

                FILL_REQ: begin
                    if (dcu.dcu_smu_ack) begin
                        // Once accepted the load cannot be recalled, so a
                        // squash here only marks the return for discard.
                        state_q <= FILL_WAIT;
                        req_q   <= 1'b0;
                        if (squash_fill || sbase_ld) begin
                            squashed_q <= 1'b1;
                        end
                    end else if (squash_fill) begin
                        state_q    <= IDLE;
                        req_q      <= 1'b0;
                        squashed_q <= 1'b0;
                    end else if (sbase_ld) begin
                        squashed_q <= 1'b1;
                    end
                end

                FILL_WAIT: begin
                    if (dcu.dcu_data_vld) begin
                        state_q    <= IDLE;
                        squashed_q <= 1'b0;
                        if (!squash_now) begin
                            we_q       <= 1'b1;
                            fill_q     <= 1'b1;
                            sbase_we_q <= 1'b1;
                            wdata_q    <= dcu.dcu_data;
                        end
                    end else if (squash_fill || sbase_ld) begin
                        squashed_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign dcu.smu_req  = req_q;
    assign dcu.smu_st   = st_q;
    assign dcu.smu_addr = addr_q;
    assign dcu.smu_data = data_q;

    assign smu_sbase     = sbase_q;
    assign smu_we        = we_q;
    assign smu_wdata     = wdata_q;
    assign smu_sbase_we  = sbase_we_q;
    assign spill         = spill_q;
    assign fill          = fill_q;
    assign less_than_6   = (num_entries < 6'd6);
    assign dribble_stall = less_than_6 && !und_flw_bit;

endmodule

// File: tb/tb_smu_dribbler.sv
// ---------------------------------------------------------------------------
// tb_smu_dribbler
// Self-checking bench for smu_dribbler. Expected spill/fill results are queued
// when a transaction is launched and compared when the completion pulse shows.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_smu_dribbler;

    logic        pj_clk = 1'b0;
    logic        pj_reset_l;
    logic        dribble_en;
    logic [5:0]  num_entries, low_mark, high_mark;
    logic        und_flw_bit;
    logic        sbase_ld;
    logic [31:0] sbase_in;
    logic [31:0] sc_rd_data;
    logic        squash_fill;
    logic [31:0] smu_sbase;
    logic        smu_we;
    logic [31:0] smu_wdata;
    logic        smu_sbase_we;
    logic        spill, fill, less_than_6, dribble_stall;

    smu_dribbler_if dcu_if ();

    smu_dribbler dut (
        .pj_clk        (pj_clk),
        .pj_reset_l    (pj_reset_l),
        .dribble_en    (dribble_en),
        .num_entries   (num_entries),
        .low_mark      (low_mark),
        .high_mark     (high_mark),
        .und_flw_bit   (und_flw_bit),
        .sbase_ld      (sbase_ld),
        .sbase_in      (sbase_in),
        .sc_rd_data    (sc_rd_data),
        .squash_fill   (squash_fill),
        .smu_sbase     (smu_sbase),
        .smu_we        (smu_we),
        .smu_wdata     (smu_wdata),
        .smu_sbase_we  (smu_sbase_we),
        .spill         (spill),
        .fill          (fill),
        .less_than_6   (less_than_6),
        .dribble_stall (dribble_stall),
        .dcu           (dcu_if)
    );

    always #5 pj_clk = ~pj_clk;

    typedef struct {
        bit          is_spill;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] sbase;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge pj_clk);
        #1;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dcu_if.smu_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic load_sbase(input logic [31:0] v);
        sbase_ld = 1'b1;
        sbase_in = v;
        tick();
        sbase_ld = 1'b0;
    endtask

    task automatic test_reset();
        pj_reset_l = 1'b0;
        #2;
        n_cmp++; if (dcu_if.smu_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", dcu_if.smu_req); end
        n_cmp++; if (smu_sbase !== 32'd0) begin n_fail++; $display("FAIL rst_sbase: got %h want 0", smu_sbase); end
        n_cmp++; if ({spill, fill, smu_we, smu_sbase_we, dcu_if.smu_st} !== 5'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 00000", {spill, fill, smu_we, smu_sbase_we, dcu_if.smu_st}); end
        n_cmp++; if ({dcu_if.smu_data, smu_wdata} !== 64'd0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {dcu_if.smu_data, smu_wdata}); end
        n_cmp++; if (less_than_6 !== 1'b0) begin n_fail++; $display("FAIL lt6_20: got %b want 0", less_than_6); end
        num_entries = 6'd5;
        und_flw_bit = 1'b1;
        #1;
        n_cmp++; if ({less_than_6, dribble_stall} !== 2'b10) begin n_fail++; $display("FAIL lt6_5_uf: got %b want 10", {less_than_6, dribble_stall}); end
        num_entries = 6'd20;
        tick();
        tick();
        pj_reset_l = 1'b1;
        tick();
    endtask

    task automatic test_spill();
        bit          seen;
        exp_t        e;
        logic [31:0] a_addr, a_data;
        load_sbase(32'h0000_1000);
        high_mark   = 6'd40;
        num_entries = 6'd45;
        sc_rd_data  = 32'hDEAD_BEEF;
        dribble_en  = 1'b1;
        sb_q.push_back('{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0FFC});
        wait_req(seen);
        dribble_en = 1'b0;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL spill_req_timeout: got 0 want 1"); end
        n_cmp++; if (dcu_if.smu_st !== 1'b1) begin n_fail++; $display("FAIL spill_st: got %b want 1", dcu_if.smu_st); end
        a_addr = dcu_if.smu_addr;
        a_data = dcu_if.smu_data;
        sc_rd_data = 32'h0BAD_0BAD;
        tick();
        tick();
        n_cmp++; if ({dcu_if.smu_req, dcu_if.smu_data} !== {1'b1, a_data}) begin n_fail++; $display("FAIL spill_hold: got %b/%h want 1/%h", dcu_if.smu_req, dcu_if.smu_data, a_data); end
        dcu_if.dcu_smu_ack = 1'b1;
        tick();
        dcu_if.dcu_smu_ack = 1'b0;
        n_cmp++; if ({spill, smu_sbase_we, fill, dcu_if.smu_req} !== 4'b1100) begin n_fail++; $display("FAIL spill_pulse: got %b want 1100", {spill, smu_sbase_we, fill, dcu_if.smu_req}); end
        e = sb_q.pop_front();
        n_cmp++; if (a_addr !== e.addr) begin n_fail++; $display("FAIL spill_addr: got %h want %h", a_addr, e.addr); end
        n_cmp++; if (a_data !== e.data) begin n_fail++; $display("FAIL spill_data: got %h want %h", a_data, e.data); end
        n_cmp++; if (smu_sbase !== e.sbase) begin n_fail++; $display("FAIL spill_sbase: got %h want %h", smu_sbase, e.sbase); end
        tick();
        n_cmp++; if ({spill, smu_sbase_we} !== 2'b00) begin n_fail++; $display("FAIL spill_one_cycle: got %b want 00", {spill, smu_sbase_we}); end
    endtask

    task automatic test_fill();
        bit          seen;
        exp_t        e;
        logic [31:0] a_addr;
        load_sbase(32'h0000_1000);
        high_mark   = 6'd40;
        low_mark    = 6'd10;
        num_entries = 6'd4;
        und_flw_bit = 1'b0;
        #1;
        n_cmp++; if (dribble_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall: got %b want 1", dribble_stall); end
        dribble_en = 1'b1;
        sb_q.push_back('{1'b0, 32'h0000_1004, 32'h1234_5678, 32'h0000_1004});
        wait_req(seen);
        dribble_en = 1'b0;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL fill_req_timeout: got 0 want 1"); end
        n_cmp++; if (dcu_if.smu_st !== 1'b0) begin n_fail++; $display("FAIL fill_st: got %b want 0", dcu_if.smu_st); end
        a_addr = dcu_if.smu_addr;
        dcu_if.dcu_smu_ack = 1'b1;
        tick();
        dcu_if.dcu_smu_ack = 1'b0;
        n_cmp++; if (dcu_if.smu_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_drop: got %b want 0", dcu_if.smu_req); end
        tick();
        tick();
        dcu_if.dcu_data_vld = 1'b1;
        dcu_if.dcu_data     = 32'h1234_5678;
        tick();
        dcu_if.dcu_data_vld = 1'b0;
        n_cmp++; if ({smu_we, fill, smu_sbase_we, spill} !== 4'b1110) begin n_fail++; $display("FAIL fill_pulse: got %b want 1110", {smu_we, fill, smu_sbase_we, spill}); end
        e = sb_q.pop_front();
        n_cmp++; if (a_addr !== e.addr) begin n_fail++; $display("FAIL fill_addr: got %h want %h", a_addr, e.addr); end
        n_cmp++; if (smu_wdata !== e.data) begin n_fail++; $display("FAIL fill_wdata: got %h want %h", smu_wdata, e.data); end
        n_cmp++; if (smu_sbase !== e.sbase) begin n_fail++; $display("FAIL fill_sbase: got %h want %h", smu_sbase, e.sbase); end
        tick();
        n_cmp++; if ({smu_we, fill} !== 2'b00) begin n_fail++; $display("FAIL fill_one_cycle: got %b want 00", {smu_we, fill}); end
    endtask

    task automatic test_squash();
        bit seen;
        load_sbase(32'h0000_3000);
        low_mark    = 6'd10;
        num_entries = 6'd4;
        und_flw_bit = 1'b0;
        // Squash while waiting for the return data.
        dribble_en = 1'b1;
        wait_req(seen);
        dribble_en = 1'b0;
        dcu_if.dcu_smu_ack = 1'b1;
        tick();
        dcu_if.dcu_smu_ack = 1'b0;
        squash_fill = 1'b1;
        tick();
        squash_fill = 1'b0;
        tick();
        dcu_if.dcu_data_vld = 1'b1;
        dcu_if.dcu_data     = 32'hAAAA_5555;
        tick();
        dcu_if.dcu_data_vld = 1'b0;
        n_cmp++; if ({smu_we, fill, smu_sbase_we} !== 3'b000) begin n_fail++; $display("FAIL sq_wait_strobes: got %b want 000", {smu_we, fill, smu_sbase_we}); end
        n_cmp++; if (smu_sbase !== 32'h0000_3000) begin n_fail++; $display("FAIL sq_wait_sbase: got %h want 00003000", smu_sbase); end
        tick();
        // A new fill must launch, proving the FSM went back to IDLE; squash it
        // before the ack.
        dribble_en = 1'b1;
        wait_req(seen);
        dribble_en = 1'b0;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL sq_idle_relaunch: got 0 want 1"); end
        squash_fill = 1'b1;
        tick();
        squash_fill = 1'b0;
        n_cmp++; if (dcu_if.smu_req !== 1'b0) begin n_fail++; $display("FAIL sq_req_drop: got %b want 0", dcu_if.smu_req); end
        dcu_if.dcu_data_vld = 1'b1;
        tick();
        dcu_if.dcu_data_vld = 1'b0;
        n_cmp++; if ({smu_we, fill} !== 2'b00) begin n_fail++; $display("FAIL sq_req_stray_vld: got %b want 00", {smu_we, fill}); end
        // SC_BOTTOM load during the wait also discards the return.
        dribble_en = 1'b1;
        wait_req(seen);
        dribble_en = 1'b0;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL sq_ld_req_timeout: got 0 want 1"); end
        dcu_if.dcu_smu_ack = 1'b1;
        tick();
        dcu_if.dcu_smu_ack = 1'b0;
        sbase_ld = 1'b1;
        sbase_in = 32'h0000_5000;
        tick();
        sbase_ld = 1'b0;
        dcu_if.dcu_data_vld = 1'b1;
        tick();
        dcu_if.dcu_data_vld = 1'b0;
        n_cmp++; if ({smu_we, fill} !== 2'b00) begin n_fail++; $display("FAIL sq_ld_strobes: got %b want 00", {smu_we, fill}); end
        n_cmp++; if (smu_sbase !== 32'h0000_5000) begin n_fail++; $display("FAIL sq_ld_sbase: got %h want 00005000", smu_sbase); end
        und_flw_bit = 1'b1;
        tick();
    endtask

    task automatic test_misconfig();
        exp_t        e;
        logic [31:0] model_sbase;
        logic [31:0] a_addr;
        int          spills = 0;
        int          fills  = 0;
        load_sbase(32'h0000_2000);
        model_sbase = 32'h0000_2000;
        a_addr      = 32'd0;
        low_mark    = 6'd50;
        high_mark   = 6'd20;
        num_entries = 6'd30;
        und_flw_bit = 1'b0;
        sc_rd_data  = 32'hCAFE_F00D;
        dribble_en  = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c == 30) dribble_en = 1'b0;
            n_cmp++; if ((spill & fill) !== 1'b0) begin n_fail++; $display("FAIL mis_both c=%0d: got %b%b want not 11", c, spill, fill); end
            if (fill === 1'b1) fills++;
            if (spill === 1'b1) begin
                spills++;
                e = sb_q.pop_front();
                n_cmp++; if ({a_addr, smu_sbase} !== {e.addr, e.sbase}) begin n_fail++; $display("FAIL mis_spill: got %h/%h want %h/%h", a_addr, smu_sbase, e.addr, e.sbase); end
            end
            if (dcu_if.smu_req === 1'b1) begin
                n_cmp++; if (dcu_if.smu_st !== 1'b1) begin n_fail++; $display("FAIL mis_st: got %b want 1", dcu_if.smu_st); end
                a_addr = dcu_if.smu_addr;
                sb_q.push_back('{1'b1, model_sbase, 32'hCAFE_F00D, model_sbase - 32'd4});
                model_sbase = model_sbase - 32'd4;
                dcu_if.dcu_smu_ack = 1'b1;
            end else begin
                dcu_if.dcu_smu_ack = 1'b0;
            end
            tick();
        end
        dcu_if.dcu_smu_ack = 1'b0;
        n_cmp++; if (fills != 0) begin n_fail++; $display("FAIL mis_fills: got %0d want 0", fills); end
        n_cmp++; if (spills < 10) begin n_fail++; $display("FAIL mis_spills: got %0d want >=10", spills); end
        n_cmp++; if (smu_sbase !== model_sbase) begin n_fail++; $display("FAIL mis_sbase: got %h want %h", smu_sbase, model_sbase); end
        und_flw_bit = 1'b1;
        tick();
    endtask

    task automatic test_wrap_load();
        bit seen;
        load_sbase(32'h0000_0000);
        high_mark   = 6'd40;
        num_entries = 6'd45;
        sc_rd_data  = 32'h55AA_55AA;
        dribble_en  = 1'b1;
        wait_req(seen);
        dribble_en = 1'b0;
        n_cmp++; if ({seen, dcu_if.smu_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_addr: got %b/%h want 1/00000000", seen, dcu_if.smu_addr); end
        dcu_if.dcu_smu_ack = 1'b1;
        tick();
        dcu_if.dcu_smu_ack = 1'b0;
        n_cmp++; if ({spill, smu_sbase} !== {1'b1, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL wrap_sbase: got %b/%h want 1/fffffffc", spill, smu_sbase); end
        tick();
        dribble_en = 1'b1;
        wait_req(seen);
        dribble_en = 1'b0;
        n_cmp++; if ({seen, dcu_if.smu_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL load_addr: got %b/%h want 1/fffffffc", seen, dcu_if.smu_addr); end
        dcu_if.dcu_smu_ack = 1'b1;
        sbase_ld = 1'b1;
        sbase_in = 32'h0000_2000;
        tick();
        dcu_if.dcu_smu_ack = 1'b0;
        sbase_ld = 1'b0;
        n_cmp++; if ({spill, smu_sbase} !== {1'b1, 32'h0000_2000}) begin n_fail++; $display("FAIL load_prio: got %b/%h want 1/00002000", spill, smu_sbase); end
        tick();
    endtask

    task automatic test_back_to_back();
        int prev = -1;
        int nreq = 0;
        load_sbase(32'h0000_4000);
        high_mark   = 6'd40;
        num_entries = 6'd45;
        sc_rd_data  = 32'h1111_0000;
        dribble_en  = 1'b1;
        for (int c = 0; c < 40 && nreq < 3; c++) begin
            if (dcu_if.smu_req === 1'b1) begin
                if (prev >= 0) begin
                    n_cmp++; if (c - prev != 2) begin n_fail++; $display("FAIL b2b_gap: got %0d want 2", c - prev); end
                end
                n_cmp++; if (dcu_if.smu_data !== 32'h1111_0000 + 32'(nreq)) begin n_fail++; $display("FAIL b2b_data: got %h want %h", dcu_if.smu_data, 32'h1111_0000 + 32'(nreq)); end
                prev = c;
                nreq++;
                dcu_if.dcu_smu_ack = 1'b1;
                sc_rd_data = 32'h1111_0000 + 32'(nreq);
                if (nreq == 3) dribble_en = 1'b0;
            end else begin
                dcu_if.dcu_smu_ack = 1'b0;
            end
            tick();
        end
        dcu_if.dcu_smu_ack = 1'b0;
        n_cmp++; if (nreq != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", nreq); end
        n_cmp++; if ({spill, smu_sbase} !== {1'b1, 32'h0000_3FF4}) begin n_fail++; $display("FAIL b2b_sbase: got %b/%h want 1/00003ff4", spill, smu_sbase); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        int bad = 0;
        load_sbase(32'h0000_1000);
        high_mark   = 6'd40;
        num_entries = 6'd45;
        dribble_en  = 1'b1;
        wait_req(seen);
        dribble_en = 1'b0;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rmid_req_timeout: got 0 want 1"); end
        pj_reset_l = 1'b0;
        #1;
        n_cmp++; if ({dcu_if.smu_req, smu_sbase} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rmid_async: got %b/%h want 0/00000000", dcu_if.smu_req, smu_sbase); end
        tick();
        pj_reset_l = 1'b1;
        dcu_if.dcu_smu_ack  = 1'b1;
        dcu_if.dcu_data_vld = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if ({spill, fill, smu_we, dcu_if.smu_req} !== 4'b0000) bad++;
        end
        dcu_if.dcu_smu_ack  = 1'b0;
        dcu_if.dcu_data_vld = 1'b0;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rmid_after: got %0d bad cycles want 0", bad); end
        n_cmp++; if (smu_sbase !== 32'h0) begin n_fail++; $display("FAIL rmid_sbase: got %h want 00000000", smu_sbase); end
    endtask

    initial begin
        pj_reset_l  = 1'b0;
        dribble_en  = 1'b0;
        num_entries = 6'd20;
        low_mark    = 6'd10;
        high_mark   = 6'd40;
        und_flw_bit = 1'b1;
        sbase_ld    = 1'b0;
        sbase_in    = 32'd0;
        sc_rd_data  = 32'd0;
        squash_fill = 1'b0;
        dcu_if.dcu_smu_ack  = 1'b0;
        dcu_if.dcu_data_vld = 1'b0;
        dcu_if.dcu_data     = 32'd0;

        test_reset();
        test_spill();
        test_fill();
        test_squash();
        test_misconfig();
        test_wrap_load();
        test_back_to_back();
        test_reset_mid();

        n_cmp++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
